change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter STOCK_INIT, default 8'd20, SHALL set the reset value of each coin stock counter.
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum cycles a coin request waits for coin_ack.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-005 change_valid  input  1  SHALL indicate that a change amount is offered by the vending stage.
REQ-006 change_amt  input  8  SHALL carry the change amount in rupees, unsigned.
REQ-007 change_ready  output  1  SHALL indicate that a new amount can be accepted.
REQ-008 coin_ack  input  1  SHALL be the hopper acknowledge that the requested coin was ejected.
REQ-009 coin20, coin10, coin05  output  1 each  SHALL be the coin eject requests, one-hot or all zero.
REQ-010 refill  input  1  SHALL be a single-cycle stock refill strobe.
REQ-011 refill_sel  input  2  SHALL select the denomination: 0=5, 1=10, 2=20, 3=ignored.
REQ-012 refill_cnt  input  8  SHALL carry the number of coins to add.
REQ-013 stock20, stock10, stock05  output  8 each  SHALL report the current coin counts.
REQ-014 done  output  1  SHALL pulse for one cycle when the full amount has been paid.
REQ-015 fault  output  1  SHALL indicate that payout stopped incomplete; it is held until cleared.
REQ-016 short_amt  output  8  SHALL report the unpaid remainder while fault=1, else 0.
REQ-017 fault_clr  input  1  SHALL release the FAULT state.

Function
REQ-018 The FSM SHALL have the states IDLE, SELECT, ISSUE, DONE and FAULT; change_ready=1 only in IDLE.
REQ-019 In IDLE, change_valid=1 SHALL load the remaining register with change_amt and move the FSM to SELECT in the same cycle.
REQ-020 SELECT SHALL pick the largest d in {20,10,5} with d<=remaining and stock_d>0, then go to ISSUE.
- remaining==0 -> DONE.
- remaining>0 with no eligible d -> FAULT; this includes remainders of 1-4.
REQ-021 In ISSUE, the selected coin output SHALL be held high until coin_ack=1 is sampled.
- On ack: remaining -= d, stock_d -= 1, next state SELECT, coin output low the following cycle.
REQ-022 coin_ack SHALL be ignored outside ISSUE.
REQ-023 An ISSUE wait counter SHALL reset on entry to ISSUE.
- If ACK_TIMEOUT cycles elapse without ack -> FAULT.
- Stock and remaining stay unchanged on timeout.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 FAULT SHALL hold fault=1 and short_amt=remaining; fault_clr=1 SHALL clear remaining and return to IDLE next cycle.
REQ-026 Refill SHALL be applied only in IDLE or FAULT, as a saturating add at 8'd255; it SHALL be ignored in other states.
REQ-027 If refill and change_valid occur in the same IDLE cycle, both SHALL take effect; the new stock is used from the first SELECT.
REQ-028 All arithmetic SHALL be 8-bit unsigned; remaining never underflows, guaranteed by the d<=remaining rule.
REQ-029 Latency: with zero-wait ack and sufficient stock, done SHALL assert 2N+2 cycles after the accept cycle, where N is the number of coins.

Reset
REQ-030 reset=0 at a rising edge SHALL force state IDLE from any state, including mid-ISSUE.
REQ-031 On that reset: remaining=0, wait counter=0, all coin outputs=0, done=0, fault=0, short_amt=0, change_ready=1, each stock=STOCK_INIT.
REQ-032 A coin request interrupted by reset SHALL NOT decrement stock.

Verification
REQ-033 Reset, then change_amt=35 with zero-wait ack -> coin20, coin10, coin05 in order; done at accept+8; stock20/10/05 = 19/19/19.
REQ-034 stock20=0, change_amt=40 -> four coin10 requests, done=1, stock10=16.
REQ-035 change_amt=27 -> coin20 then coin05; fault=1, short_amt=2; fault_clr -> IDLE with change_ready=1.
REQ-036 coin_ack held low for 16 cycles during ISSUE -> fault=1, short_amt equals the loaded amount, stock unchanged.
REQ-037 refill sel=2, cnt=250 with stock20=20 -> stock20=255 (saturated); a refill issued during ISSUE -> ignored.
REQ-038 reset driven low mid-ISSUE of amount 50 -> next cycle all coins low, stocks=STOCK_INIT, change_ready=1.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: pays a rupee amount as 20/10/5 coins (largest coin first),
// one hopper request at a time, tracking per-denomination stock.
// An unpayable remainder or a hopper that never acknowledges parks the block
// in FAULT until fault_clr.
module change_dispenser #(
  parameter logic [7:0] STOCK_INIT  = 8'd20,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [7:0] change_amt,
  output logic       change_ready,
  input  logic       coin_ack,
  output logic       coin20,
  output logic       coin10,
  output logic       coin05,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  input  logic [7:0] refill_cnt,
  output logic [7:0] stock20,
  output logic [7:0] stock10,
  output logic [7:0] stock05,
  output logic       done,
  output logic       fault,
  output logic [7:0] short_amt,
  input  logic       fault_clr
);

  // The wait counter only has to reach ACK_TIMEOUT-1.
  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        remaining;
  logic [7:0]        coin_val;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        pick_val;
  logic [2:0]        pick_coin;
  logic              refill_ok;

  // Add coins to a stock counter, clamping at 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

  // Choose the largest coin that fits the remainder and is still in stock.
  always_comb begin
    pick_val  = 8'd0;
    pick_coin = 3'b000;
    if ((remaining >= 8'd20) && (stock20 != 8'd0)) begin
      pick_val  = 8'd20;
      pick_coin = 3'b100;
    end else if ((remaining >= 8'd10) && (stock10 != 8'd0)) begin
      pick_val  = 8'd10;
      pick_coin = 3'b010;
    end else if ((remaining >= 8'd5) && (stock05 != 8'd0)) begin
      pick_val  = 8'd5;
      pick_coin = 3'b001;
    end else begin
      pick_val  = 8'd0;
      pick_coin = 3'b000;
    end
  end

  // Refills are only honoured while no coin is in flight.
  always_comb begin
    if (refill && ((state == S_IDLE) || (state == S_FAULT))) begin
      refill_ok = 1'b1;
    end else begin
      refill_ok = 1'b0;
    end
  end

  // Payout state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      remaining    <= 8'd0;
      coin_val     <= 8'd0;
      wait_cnt     <= '0;
      coin20       <= 1'b0;
      coin10       <= 1'b0;
      coin05       <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      short_amt    <= 8'd0;
      change_ready <= 1'b1;
      stock20      <= STOCK_INIT;
      stock10      <= STOCK_INIT;
      stock05      <= STOCK_INIT;
    end else begin
      // Refill is exclusive with ISSUE, so it never collides with a decrement.
      if (refill_ok) begin
        case (refill_sel)
          2'd0:    stock05 <= sat_add(stock05, refill_cnt);
          2'd1:    stock10 <= sat_add(stock10, refill_cnt);
          2'd2:    stock20 <= sat_add(stock20, refill_cnt);
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (change_valid) begin
            remaining    <= change_amt;
            change_ready <= 1'b0;
            state        <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (remaining == 8'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (pick_coin != 3'b000) begin
            {coin20, coin10, coin05} <= pick_coin;
            coin_val <= pick_val;
            wait_cnt <= '0;
            state    <= S_ISSUE;
          end else begin
            fault     <= 1'b1;
            short_amt <= remaining;
            state     <= S_FAULT;
          end
        end

        S_ISSUE: begin
          if (coin_ack) begin
            // coin_val <= remaining was guaranteed at selection time.
            remaining <= remaining - coin_val;
            if (coin20) begin
              stock20 <= stock20 - 8'd1;
            end else if (coin10) begin
              stock10 <= stock10 - 8'd1;
            end else if (coin05) begin
              stock05 <= stock05 - 8'd1;
            end
            {coin20, coin10, coin05} <= 3'b000;
            state <= S_SELECT;
          end else if (wait_cnt == WAIT_LAST) begin
            // Hopper never answered: nothing was paid for this request.
            {coin20, coin10, coin05} <= 3'b000;
            fault     <= 1'b1;
            short_amt <= remaining;
            state     <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_DONE: begin
          done         <= 1'b0;
          change_ready <= 1'b1;
          state        <= S_IDLE;
        end

        S_FAULT: begin
          if (fault_clr) begin
            remaining    <= 8'd0;
            fault        <= 1'b0;
            short_amt    <= 8'd0;
            change_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: begin
          {coin20, coin10, coin05} <= 3'b000;
          remaining    <= 8'd0;
          done         <= 1'b0;
          fault        <= 1'b0;
          short_amt    <= 8'd0;
          change_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
